// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU core: FSM states, opcodes,
// ALU selects and SKIPCOND test codes.
package acc_cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL0  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_ILL5  = 4'h5,
    OP_ILL6  = 4'h6,
    OP_HALT  = 4'h7,
    OP_SKIP  = 4'h8,
    OP_JUMP  = 4'h9,
    OP_CLEAR = 4'hA,
    OP_INC   = 4'hB,
    OP_DEC   = 4'hC,
    OP_ADDI  = 4'hD,
    OP_SUBI  = 4'hE,
    OP_ANDI  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_e;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/acc_cpu_core_if.sv
// Single-port synchronous RAM request/acknowledge bus; the core is master.
interface acc_cpu_core_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU shared by all accumulator arithmetic: add, sub, and.
module alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  alu_op_e            i_sel,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_y
);

  always_comb begin
    o_y = '0;
    case (i_sel)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: fetch / decode / memory-execute FSM with
// PC, IR, MBR and AC, talking to one RAM over a req/ack bus.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RESET_PC   = 'h100,
  parameter int unsigned PC_STEP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  acc_cpu_core_if.master        mem,
  output logic                  halted,
  output logic                  illegal,
  output logic                  instr_done,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic [DATA_WIDTH-1:0] ac_o
);

  localparam int unsigned OPW = DATA_WIDTH - 4;
  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(PC_STEP);

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
  logic [DATA_WIDTH-1:0] r_mbr, w_mbr_nxt;
  logic [DATA_WIDTH-1:0] r_ac, w_ac_nxt;
  logic                  r_illegal, w_illegal_nxt;

  opcode_e               w_op;
  logic [OPW-1:0]        w_operand;
  logic [ADDR_WIDTH-1:0] w_op_addr;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [1:0]            w_skip_sel;
  logic                  w_skip_take;
  alu_op_e               w_alu_sel;
  logic [DATA_WIDTH-1:0] w_alu_b, w_alu_y;
  logic                  w_req, w_we, w_done;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_op       = opcode_e'(r_ir[DATA_WIDTH-1 -: 4]);
  assign w_operand  = r_ir[OPW-1:0];
  assign w_imm      = {4'b0000, w_operand};
  assign w_skip_sel = r_ir[OPW-1 -: 2];

  generate
    if (ADDR_WIDTH > OPW) begin : g_addr_ext
      assign w_op_addr = {{(ADDR_WIDTH-OPW){1'b0}}, w_operand};
    end else if (ADDR_WIDTH == OPW) begin : g_addr_eq
      assign w_op_addr = w_operand;
    end else begin : g_addr_trunc
      assign w_op_addr = w_operand[ADDR_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    w_skip_take = 1'b0;
    case (w_skip_sel)
      SKIP_NEG:   w_skip_take = r_ac[DATA_WIDTH-1];
      SKIP_ZERO:  w_skip_take = (r_ac == '0);
      SKIP_POS:   w_skip_take = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
      SKIP_NEVER: w_skip_take = 1'b0;
      default:    w_skip_take = 1'b0;
    endcase
  end

  alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .i_sel (w_alu_sel),
    .i_a   (r_ac),
    .i_b   (w_alu_b),
    .o_y   (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= PC_RST;
      r_ir      <= '0;
      r_mbr     <= '0;
      r_ac      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_mbr     <= w_mbr_nxt;
      r_ac      <= w_ac_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_mbr_nxt     = r_mbr;
    w_ac_nxt      = r_ac;
    w_illegal_nxt = r_illegal;
    w_req         = 1'b0;
    w_we          = 1'b0;
    w_addr        = r_pc;
    w_done        = 1'b0;
    w_alu_sel     = ALU_ADD;
    w_alu_b       = mem.mem_rdata;

    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_req = 1'b1;
          if (mem.mem_ack) begin
            w_ir_nxt    = mem.mem_rdata;
            w_pc_nxt    = r_pc + PC_INC;
            w_state_nxt = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_LOAD, OP_ADD, OP_SUB: w_state_nxt = S_MEM;
          // Store data is staged in MBR here; AC cannot change before the write completes.
          OP_STORE: begin
            w_mbr_nxt   = r_ac;
            w_state_nxt = S_MEM;
          end
          OP_HALT: begin
            w_state_nxt = S_HALT;
            w_done      = 1'b1;
          end
          OP_SKIP: begin
            if (w_skip_take) w_pc_nxt = r_pc + PC_INC;
            w_done = 1'b1;
          end
          OP_JUMP: begin
            w_pc_nxt = w_op_addr;
            w_done   = 1'b1;
          end
          OP_CLEAR: begin
            w_ac_nxt = '0;
            w_done   = 1'b1;
          end
          OP_INC, OP_DEC: begin
            w_alu_sel = (w_op == OP_INC) ? ALU_ADD : ALU_SUB;
            w_alu_b   = DATA_WIDTH'(1);
            w_ac_nxt  = w_alu_y;
            w_done    = 1'b1;
          end
          OP_ADDI, OP_SUBI, OP_ANDI: begin
            w_alu_sel = (w_op == OP_ADDI) ? ALU_ADD :
                        (w_op == OP_SUBI) ? ALU_SUB : ALU_AND;
            w_alu_b   = w_imm;
            w_ac_nxt  = w_alu_y;
            w_done    = 1'b1;
          end
          default: begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        w_req     = 1'b1;
        w_we      = (w_op == OP_STORE);
        w_addr    = w_op_addr;
        w_alu_sel = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
        if (mem.mem_ack) begin
          if (w_op != OP_STORE) w_mbr_nxt = mem.mem_rdata;
          if (w_op == OP_LOAD) w_ac_nxt = mem.mem_rdata;
          else if (w_op != OP_STORE) w_ac_nxt = w_alu_y;
          w_done      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      S_HALT: w_state_nxt = S_HALT;

      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Gating with rst_n drops a pending request in the same cycle reset asserts.
  assign mem.mem_req   = w_req & rst_n;
  assign mem.mem_we    = w_we & rst_n;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = r_mbr;

  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;
  assign instr_done = w_done;
  assign pc_o       = r_pc;
  assign ir_o       = r_ir;
  assign ac_o       = r_ac;

endmodule
